// File: rtl/sonar_scan_scheduler_if.sv
// Measurement bus from sonar_scan_scheduler to the controller logic.
//   meas_valid   : one-cycle strobe, a measurement is ready
//   meas_id      : index of the sensor that was measured
//   meas_width   : echo width in clocks (saturated at the timeout)
//   meas_timeout : the measurement ended by timeout
// master = scheduler (drives), slave = consumer (receives).
interface sonar_scan_scheduler_if #(
  parameter int N_SENS = 4,
  parameter int CNT_W  = 21
);
  localparam int ID_W = $clog2(N_SENS);

  logic             meas_valid;
  logic [ID_W-1:0]  meas_id;
  logic [CNT_W-1:0] meas_width;
  logic             meas_timeout;

  modport master (output meas_valid, output meas_id, output meas_width, output meas_timeout);
  modport slave  (input  meas_valid, input  meas_id, input  meas_width, input  meas_timeout);
endinterface

// File: rtl/sonar_scan_scheduler.sv
// sonar_scan_scheduler: round-robin ultrasonic rangefinder scheduler.
// Fires each sensor's TRIGGER in turn, measures the synchronized ECHO pulse
// width with timeout protection, reports one tagged measurement per ping and
// keeps a quiet gap between pings.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   enable   : run scanning while high (a ping in progress always completes)
//   echo     : asynchronous ECHO lines, one per sensor
//   trigger  : registered TRIGGER lines, at most one high
//   near     : per-sensor near-object flags
//   meas     : measurement bus (sonar_scan_scheduler_if.master)
// Optional feature macro: SONAR_NEAR_DETECT_EN enables the near-object
// comparator and flags; when undefined, near is tied to 0.
module sonar_scan_scheduler #(
  parameter int N_SENS         = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 3_000_000,
  parameter int THRESH_CYCLES  = 117_647,
  parameter int CNT_W          = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_SENS-1:0]     echo,
  output logic [N_SENS-1:0]     trigger,
  output logic [N_SENS-1:0]     near,
  sonar_scan_scheduler_if.master meas
);
  localparam int ID_W  = $clog2(N_SENS);
  // The phase timer also times the gap, which can exceed the width field.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMR_W = (GAP_W > CNT_W) ? GAP_W : CNT_W;

  localparam logic [TMR_W-1:0] LP_TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] LP_TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LP_GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_W_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_W_MAX     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0]  LP_IDX_LAST  = ID_W'(N_SENS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_idx, w_idx_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [CNT_W-1:0] r_width, w_width_nxt;
  logic             r_to, w_to_nxt;

  logic [N_SENS-1:0] r_echo_m, r_echo_s, r_echo_d;
  logic              w_echo, w_rise, w_fall;

  logic [N_SENS-1:0] r_trigger;
  logic              r_meas_valid;
  logic [ID_W-1:0]   r_meas_id;
  logic [CNT_W-1:0]  r_meas_width;
  logic              r_meas_to;

  // r_echo_d is the previous synchronized value; it tracks continuously so an
  // echo already high when WAIT_RISE is entered yields no rise edge.
  assign w_echo = r_echo_s[r_idx];
  assign w_rise = w_echo & ~r_echo_d[r_idx];
  assign w_fall = ~w_echo & r_echo_d[r_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tmr_nxt   = r_tmr;
    w_width_nxt = r_width;
    w_to_nxt    = r_to;
    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        if (enable) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (r_tmr == LP_TRIG_LAST) begin
          w_state_nxt = S_WAIT_RISE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_width_nxt = '0;
        end else if (r_tmr == LP_TO_LAST) begin
          w_state_nxt = S_REPORT;
          w_width_nxt = '0;
          w_to_nxt    = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_MEASURE: begin
        if (w_fall) begin
          w_state_nxt = S_REPORT;
          w_to_nxt    = 1'b0;
        end else if (w_echo) begin
          if (r_width == LP_W_LAST) begin
            w_state_nxt = S_REPORT;
            w_width_nxt = LP_W_MAX;
            w_to_nxt    = 1'b1;
          end else begin
            w_width_nxt = r_width + 1'b1;
          end
        end
      end
      S_REPORT: begin
        w_state_nxt = S_GAP;
        w_tmr_nxt   = '0;
      end
      S_GAP: begin
        if (r_tmr == LP_GAP_LAST) begin
          w_tmr_nxt   = '0;
          w_idx_nxt   = (r_idx == LP_IDX_LAST) ? '0 : r_idx + 1'b1;
          w_state_nxt = enable ? S_TRIG : S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_tmr        <= '0;
      r_width      <= '0;
      r_to         <= 1'b0;
      r_echo_m     <= '0;
      r_echo_s     <= '0;
      r_echo_d     <= '0;
      r_trigger    <= '0;
      r_meas_valid <= 1'b0;
      r_meas_id    <= '0;
      r_meas_width <= '0;
      r_meas_to    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_tmr        <= w_tmr_nxt;
      r_width      <= w_width_nxt;
      r_to         <= w_to_nxt;
      r_echo_m     <= echo;
      r_echo_s     <= r_echo_m;
      r_echo_d     <= r_echo_s;
      // Trigger follows the state one clock later, so it is high for exactly
      // the TRIG_CYCLES clocks spent in S_TRIG.
      r_trigger    <= (r_state == S_TRIG) ? (N_SENS'(1) << r_idx) : '0;
      r_meas_valid <= (w_state_nxt == S_REPORT);
      if (w_state_nxt == S_REPORT) begin
        r_meas_id    <= r_idx;
        r_meas_width <= w_width_nxt;
        r_meas_to    <= w_to_nxt;
      end
    end
  end

`ifdef SONAR_NEAR_DETECT_EN
  logic [N_SENS-1:0] r_near;
  localparam logic [CNT_W-1:0] LP_THRESH = CNT_W'(THRESH_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_near <= '0;
    end else if (w_state_nxt == S_REPORT) begin
      r_near[r_idx] <= ~w_to_nxt & (w_width_nxt < LP_THRESH);
    end
  end

  assign near = r_near;
`else
  assign near = '0;
`endif

  assign trigger           = r_trigger;
  assign meas.meas_valid   = r_meas_valid;
  assign meas.meas_id      = r_meas_id;
  assign meas.meas_width   = r_meas_width;
  assign meas.meas_timeout = r_meas_to;
endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Directed testbench for sonar_scan_scheduler with shortened timing parameters.
// Honours SONAR_NEAR_DETECT_EN for the expected near flags.
module tb_sonar_scan_scheduler;
  localparam int NS    = 4;
  localparam int CW    = 21;
  localparam int TRIG  = 50;
  localparam int GAP   = 1000;
  localparam int TMO   = 6000;
  localparam int THR   = 2000;
  localparam int BOUND = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [NS-1:0] echo;
  logic [NS-1:0] trigger;
  logic [NS-1:0] near;

  sonar_scan_scheduler_if #(.N_SENS(NS), .CNT_W(CW)) u_if ();

  sonar_scan_scheduler #(
    .N_SENS(NS), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(GAP), .THRESH_CYCLES(THR), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo),
    .trigger(trigger), .near(near), .meas(u_if)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid = 0;
  int n_overlap = 0;
  logic [NS-1:0] exp_near = '0;

  always @(negedge clk) begin
    if (u_if.meas_valid === 1'b1) n_valid++;
    if ($countones(trigger) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int unsigned tol = 0);
    logic [31:0] diff;
    n_checks++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if ((^obs === 1'bx) || (diff > tol)) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a trigger, checks which bit fired, its high time and stability.
  // Returns at the first sample with trigger low.
  task automatic wait_trig(input string tag, input logic [NS-1:0] exp_t);
    int t = 0;
    int h = 0;
    int bad = 0;
    while (trigger == '0 && t < BOUND) begin @(negedge clk); t++; end
    check({tag, "_trig"}, 32'(trigger), 32'(exp_t));
    while (trigger != '0 && h < BOUND) begin
      if (trigger != exp_t) bad++;
      @(negedge clk);
      h++;
    end
    check({tag, "_tlen"}, h, TRIG);
    check({tag, "_tstable"}, bad, 0);
  endtask

  task automatic pulse(input int idx, input int w);
    echo[idx] = 1'b1;
    cyc(w);
    echo[idx] = 1'b0;
  endtask

  // Waits for meas_valid and checks the report; lat = samples waited.
  task automatic wait_meas(input string tag, input int id, input int w, input int tol,
                           input logic to, output int lat);
    lat = 0;
    while (u_if.meas_valid !== 1'b1 && lat < BOUND) begin @(negedge clk); lat++; end
    check({tag, "_valid"}, 32'(u_if.meas_valid), 1);
    check({tag, "_id"}, 32'(u_if.meas_id), id);
    check({tag, "_width"}, 32'(u_if.meas_width), w, tol);
    check({tag, "_to"}, 32'(u_if.meas_timeout), 32'(to));
`ifdef SONAR_NEAR_DETECT_EN
    exp_near[id] = !to && (w < THR);
`endif
    check({tag, "_near"}, 32'(near), 32'(exp_near));
    @(negedge clk);
    check({tag, "_strobe"}, 32'(u_if.meas_valid), 0);
  endtask

  initial begin
    int lat;
    int cnt;
    int v0;
    rst = 1'b1;
    enable = 1'b1;
    echo = '0;

    // Reset with enable high
    cyc(3);
    check("rst_trig", 32'(trigger), 0);
    check("rst_valid", 32'(u_if.meas_valid), 0);
    check("rst_id", 32'(u_if.meas_id), 0);
    check("rst_width", 32'(u_if.meas_width), 0);
    check("rst_to", 32'(u_if.meas_timeout), 0);
    check("rst_near", 32'(near), 0);
    rst = 1'b0;

    // Nominal echo on sensor 0
    wait_trig("p0", 4'b0001);
    cyc(20);
    pulse(0, 588);
    wait_meas("p0", 0, 588, 1, 1'b0, lat);

    // Round robin through sensors 1..3 and wrap to 0
    wait_trig("p1", 4'b0010);
    cyc(20); pulse(1, 2500);
    wait_meas("p1", 1, 2500, 1, 1'b0, lat);
    wait_trig("p2", 4'b0100);
    cyc(20); pulse(2, 1000);
    wait_meas("p2", 2, 1000, 1, 1'b0, lat);
    wait_trig("p3", 4'b1000);
    cyc(20); pulse(3, 1617);
    wait_meas("p3", 3, 1617, 1, 1'b0, lat);
    wait_trig("p4", 4'b0001);
    cyc(20); pulse(0, 2177);
    wait_meas("p4", 0, 2177, 1, 1'b0, lat);

    // No echo on sensor 1: timeout reported TMO clocks after trigger falls
    wait_trig("tmo", 4'b0010);
    wait_meas("tmo", 1, 0, 0, 1'b1, lat);
    check("tmo_lat", lat, TMO, 1);

    // Over-long echo on sensor 2 saturates the width
    wait_trig("sat", 4'b0100);
    cyc(20);
    echo[2] = 1'b1;
    wait_meas("sat", 2, TMO, 0, 1'b1, lat);
    cyc(500);
    echo[2] = 1'b0;

    // Drop enable mid-measure on sensor 3; report completes, then idle
    wait_trig("en", 4'b1000);
    cyc(20);
    echo[3] = 1'b1;
    cyc(100);
    enable = 1'b0;
    cyc(400);
    echo[3] = 1'b0;
    wait_meas("en", 3, 500, 1, 1'b0, lat);
    cnt = 0;
    for (int i = 0; i < GAP + 200; i++) begin
      if (trigger != '0) cnt++;
      @(negedge clk);
    end
    check("en_idle_trig", cnt, 0);
    enable = 1'b1;
    wait_trig("en_resume", 4'b0001);
    cyc(20); pulse(0, 300);
    wait_meas("p5", 0, 300, 1, 1'b0, lat);

    // Stale echo on sensor 1, cross-talk on sensor 2
    echo[1] = 1'b1;
    wait_trig("stale", 4'b0010);
    for (int i = 0; i < 20; i++) begin
      echo[2] = ~echo[2];
      cyc(10);
    end
    echo[1] = 1'b0;
    echo[2] = 1'b1;
    cyc(100);
    echo[2] = 1'b0;
    fork
      pulse(1, 3000);
      begin
        for (int i = 0; i < 50; i++) begin
          echo[2] = ~echo[2];
          cyc(25);
        end
        echo[2] = 1'b0;
      end
    join
    wait_meas("stale", 1, 3000, 1, 1'b0, lat);

    // Reset in the middle of measuring sensor 2
    wait_trig("mrst", 4'b0100);
    cyc(20);
    echo[2] = 1'b1;
    cyc(200);
    v0 = n_valid;
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_near = '0;
    check("mrst_trig", 32'(trigger), 0);
    check("mrst_valid", 32'(u_if.meas_valid), 0);
    check("mrst_id", 32'(u_if.meas_id), 0);
    check("mrst_width", 32'(u_if.meas_width), 0);
    check("mrst_to", 32'(u_if.meas_timeout), 0);
    check("mrst_near", 32'(near), 0);
    cyc(300);
    echo[2] = 1'b0;
    cyc(100);
    check("mrst_noreport", n_valid - v0, 0);
    enable = 1'b1;
    wait_trig("mrst_resume", 4'b0001);

    check("reports", n_valid, 10);
    check("overlap", n_overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
